pipeline_stage_buffer: RTL and testbench
========================================

# pipeline_stage_buffer

Parametrised pipeline register for the processor datapath, replacing hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a data payload and a control-signal bundle between stages, adds valid/ready flow control through a two-entry skid buffer, and supports flush-to-bubble. A saturating stall counter records back-pressure for performance debug.

## Interface
- DATA_WIDTH, 32: payload bits (PC+4, instruction, operands, immediates, register index, concatenated).
- CTRL_WIDTH, 11: control bits; forced to zero whenever the stage holds a bubble.
- CNT_WIDTH, 16: stall counter width.
- clk  input  1  stage clock; all state updates on the falling edge, matching the rest of the pipeline.
- reset  input  1  asynchronous, active-low reset.
- in_Valid  input  1  upstream presents a valid entry.
- in_Ready  output  1  buffer can accept an entry this cycle.
- in_Data  input  DATA_WIDTH  upstream payload.
- in_Ctrl  input  CTRL_WIDTH  upstream control bundle.
- in_Flush  input  1  kill all held entries (branch/jump taken).
- out_Valid  output  1  head entry valid.
- out_Ready  input  1  downstream accepts the head entry.
- out_Data  output  DATA_WIDTH  head payload.
- out_Ctrl  output  CTRL_WIDTH  head control; all zero when out_Valid=0.
- out_StallCount  output  CNT_WIDTH  saturating count of stalled cycles.

## Operation
- Storage: main entry (data, ctrl) and skid entry (data, ctrl). Occupancy state EMPTY, ONE or FULL.
- in_Ready = (state != FULL). It is a function of state only, with no combinational path from out_Ready.
- out_Valid = (state != EMPTY). out_Data = main data. out_Ctrl = main ctrl gated by out_Valid.
- An accept is in_Valid && in_Ready at the edge. A drain is out_Valid && out_Ready at the edge.
- Transitions at each falling edge when in_Flush=0:
  - EMPTY: accept loads main and moves to ONE. Otherwise the state holds.
  - ONE, accept and drain: main <= input, state stays ONE.
  - ONE, accept only: skid <= input, state moves to FULL.
  - ONE, drain only: state moves to EMPTY.
  - ONE, neither: state holds.
  - FULL, drain: main <= skid, state moves to ONE. No accept is possible in FULL.
  - FULL, no drain: state holds.
- Flush: in_Flush=1 at an edge forces EMPTY and zeroes both ctrl registers. Data registers keep their values. Flush has priority over a simultaneous accept (the input is discarded) and a simultaneous drain (downstream sees the drain, but the state still ends EMPTY).
- Stall counter: increments at each edge where out_Valid=1 and out_Ready=0. It saturates at 2^CNT_WIDTH-1. Only reset clears it; flush does not.
- Ordering: entries leave in acceptance order. No entry is duplicated or dropped except by flush.

## Timing
- Reset asserted (asynchronous, immediate) and held:
  - state EMPTY, all data/ctrl registers 0, counter 0.
  - Outputs: out_Valid=0, out_Data=0, out_Ctrl=0, out_StallCount=0, in_Ready=1.
- Reset asserted mid-operation discards all entries immediately. The first accept can occur at the first falling edge after reset deasserts.
- Latency: an entry accepted at edge N appears on out_* right after edge N.
- Throughput: one entry per cycle while out_Ready=1.
- Back-pressure: when out_Ready drops, in_Ready stays 1 for one more cycle so the skid entry can absorb an in-flight item. in_Ready falls only after the buffer reaches FULL.
- All outputs are registered or gated from registers. Only in_Ready depends on state; no output depends combinationally on in_* or out_Ready.

## Test plan
- Reset: reset=0 mid-stream with FULL state -> out_Valid=0, out_Ctrl=0, out_Data=0, in_Ready=1, out_StallCount=0 immediately, before any clk edge.
- Streaming: out_Ready=1, send data 0x1..0x8 with ctrl 0x7FF on consecutive edges -> same sequence on out_Data one edge later, in_Ready constantly 1, out_StallCount=0.
- Skid fill/drain:
  - Stimulus: hold out_Ready=0 while sending 0xA, 0xB, 0xC.
  - Required: 0xA held in main, 0xB in skid, in_Ready=0 after the second edge, 0xC not accepted while in_Ready=0.
  - Release out_Ready: outputs 0xA, 0xB, then 0xC.
- Flush priority: state FULL, in_Flush=1 with in_Valid=1 (0xD) and out_Ready=1 -> next cycle out_Valid=0, out_Ctrl=0, in_Ready=1, and 0xD never appears.
- Bubble gating: state EMPTY with ctrl register previously 0x5A5 -> out_Ctrl=0 while out_Valid=0.
- Counter saturation: CNT_WIDTH=4, out_Valid=1 and out_Ready=0 for 20 edges -> out_StallCount reaches 15 and stays 15. It is unchanged by a flush and clears only on reset.

Source files
------------

// File: rtl/pipeline_stage_buffer.sv
// ---------------------------------------------------------------------------
// pipeline_stage_buffer
//
// Generic pipeline register placed between datapath stages (IF/ID, ID/EX,
// EX/MEM, MEM/WB). It carries a data payload and a control bundle. Flow
// control is valid/ready through a two-entry skid buffer. Flush turns the
// stage into a bubble. A saturating counter records back-pressure cycles.
// All state updates on the falling clock edge, like the rest of the pipeline.
//
// Ports
//   clk            stage clock (falling-edge active)
//   reset          asynchronous, active-low reset
//   in_Valid       upstream presents an entry
//   in_Ready       buffer can accept an entry (depends on occupancy only)
//   in_Data        upstream payload
//   in_Ctrl        upstream control bundle
//   in_Flush       kill all held entries (taken branch / jump)
//   out_Valid      head entry valid
//   out_Ready      downstream accepts the head entry
//   out_Data       head payload
//   out_Ctrl       head control, zero while the stage holds a bubble
//   out_StallCount saturating count of cycles with valid head and no ready
// ---------------------------------------------------------------------------
module pipeline_stage_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_WIDTH = 11,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_Valid,
   output logic                  in_Ready,
   input  logic [DATA_WIDTH-1:0] in_Data,
   input  logic [CTRL_WIDTH-1:0] in_Ctrl,
   input  logic                  in_Flush,
   output logic                  out_Valid,
   input  logic                  out_Ready,
   output logic [DATA_WIDTH-1:0] out_Data,
   output logic [CTRL_WIDTH-1:0] out_Ctrl,
   output logic [CNT_WIDTH-1:0]  out_StallCount
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                state;
   state_t                nextState;

   logic [DATA_WIDTH-1:0] mainData;
   logic [CTRL_WIDTH-1:0] mainCtrl;
   logic [DATA_WIDTH-1:0] skidData;
   logic [CTRL_WIDTH-1:0] skidCtrl;
   logic [CNT_WIDTH-1:0]  stallCount;

   logic                  accept;
   logic                  drain;
   logic                  loadMainIn;
   logic                  loadMainSkid;
   logic                  loadSkid;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // in_Ready is decoded from occupancy alone so out_Ready never reaches the
   // upstream stage combinationally; the skid entry absorbs the one in-flight
   // item that arrives while the downstream stall is being noticed.
   assign in_Ready  = (state != FULL);
   assign out_Valid = (state != EMPTY);
   assign accept    = in_Valid && in_Ready;
   assign drain     = out_Valid && out_Ready;

   // --- occupancy next-state and load selects ---
   always_comb begin
      nextState    = state;
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
      if (in_Flush) begin
         // Flush wins over any simultaneous accept or drain.
         nextState = EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  loadMainIn = 1'b1;
                  nextState  = ONE;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  loadMainIn = 1'b1;
               end else if (accept) begin
                  loadSkid  = 1'b1;
                  nextState = FULL;
               end else if (drain) begin
                  nextState = EMPTY;
               end
            end
            FULL: begin
               if (drain) begin
                  loadMainSkid = 1'b1;
                  nextState    = ONE;
               end
            end
            default: nextState = EMPTY;
         endcase
      end
   end

   // --- occupancy register ---
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state <= EMPTY;
      end else begin
         state <= nextState;
      end
   end

   // --- payload registers (flush leaves data untouched) ---
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         mainData <= '0;
         skidData <= '0;
      end else begin
         if (loadMainIn) begin
            mainData <= in_Data;
         end else if (loadMainSkid) begin
            mainData <= skidData;
         end
         if (loadSkid) begin
            skidData <= in_Data;
         end
      end
   end

   // --- control registers (flush forces a bubble) ---
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         mainCtrl <= '0;
         skidCtrl <= '0;
      end else if (in_Flush) begin
         mainCtrl <= '0;
         skidCtrl <= '0;
      end else begin
         if (loadMainIn) begin
            mainCtrl <= in_Ctrl;
         end else if (loadMainSkid) begin
            mainCtrl <= skidCtrl;
         end
         if (loadSkid) begin
            skidCtrl <= in_Ctrl;
         end
      end
   end

   // --- stall counter (only reset clears it) ---
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         stallCount <= '0;
      end else if (out_Valid && !out_Ready) begin
         stallCount <= satInc(stallCount);
      end
   end

   assign out_Data       = mainData;
   assign out_Ctrl       = out_Valid ? mainCtrl : '0;
   assign out_StallCount = stallCount;

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
module tb_pipeline_stage_buffer;

   localparam int DW = 32;
   localparam int CW = 11;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_Valid;
   logic          in_Ready;
   logic [DW-1:0] in_Data;
   logic [CW-1:0] in_Ctrl;
   logic          in_Flush;
   logic          out_Valid;
   logic          out_Ready;
   logic [DW-1:0] out_Data;
   logic [CW-1:0] out_Ctrl;
   logic [NW-1:0] out_StallCount;

   int total = 0;
   int bad   = 0;

   logic [DW+CW-1:0] expQ[$];

   pipeline_stage_buffer #(
      .DATA_WIDTH(DW),
      .CTRL_WIDTH(CW),
      .CNT_WIDTH (NW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_Valid      (in_Valid),
      .in_Ready      (in_Ready),
      .in_Data       (in_Data),
      .in_Ctrl       (in_Ctrl),
      .in_Flush      (in_Flush),
      .out_Valid     (out_Valid),
      .out_Ready     (out_Ready),
      .out_Data      (out_Data),
      .out_Ctrl      (out_Ctrl),
      .out_StallCount(out_StallCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance past the next active (falling) edge; outputs are then settled.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic pushExp(input logic [DW-1:0] d, input logic [CW-1:0] c);
      expQ.push_back({d, c});
   endtask

   // Monitor: a drain happens at the next falling edge whenever the head is
   // valid and ready while clk is high, so sample on the rising edge.
   always @(posedge clk) begin
      if (reset && out_Valid && out_Ready) begin
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("FAIL drain_unexpected: got data 0x%0h ctrl 0x%0h expected no entry", out_Data, out_Ctrl);
         end else begin
            logic [DW+CW-1:0] e;
            e = expQ.pop_front();
            if ({out_Data, out_Ctrl} !== e) begin
               bad++;
               $display("FAIL drain_order: got data 0x%0h ctrl 0x%0h expected data 0x%0h ctrl 0x%0h",
                        out_Data, out_Ctrl, e[DW+CW-1:CW], e[CW-1:0]);
            end
         end
      end
   end

   initial begin
      reset     = 1'b0;
      in_Valid  = 1'b0;
      in_Data   = '0;
      in_Ctrl   = '0;
      in_Flush  = 1'b0;
      out_Ready = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_Valid), 0);
      chk("rst_in_ready", 32'(in_Ready), 1);
      chk("rst_out_data", out_Data, 0);
      chk("rst_out_ctrl", 32'(out_Ctrl), 0);
      chk("rst_stall", 32'(out_StallCount), 0);
      cyc();
      cyc();
      reset = 1'b1;

      // Streaming at full rate
      out_Ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_Valid = 1'b1;
         in_Data  = 32'(i);
         in_Ctrl  = 11'h7FF;
         pushExp(32'(i), 11'h7FF);
         chk("stream_in_ready", 32'(in_Ready), 1);
         cyc();
         chk("stream_out_data", out_Data, 32'(i));
         chk("stream_out_ctrl", 32'(out_Ctrl), 32'h7FF);
      end
      in_Valid = 1'b0;
      cyc();
      chk("stream_empty", 32'(out_Valid), 0);
      chk("stream_stall", 32'(out_StallCount), 0);

      // Skid fill and drain
      out_Ready = 1'b0;
      in_Valid  = 1'b1;
      in_Data   = 32'hA;
      in_Ctrl   = 11'h123;
      cyc();
      chk("skid_a_head", out_Data, 32'hA);
      chk("skid_ready_one", 32'(in_Ready), 1);
      in_Data = 32'hB;
      in_Ctrl = 11'h124;
      cyc();
      chk("skid_full_ready", 32'(in_Ready), 0);
      chk("skid_head_held", out_Data, 32'hA);
      in_Data = 32'hC;
      in_Ctrl = 11'h125;
      cyc();
      chk("skid_c_blocked", 32'(in_Ready), 0);
      chk("skid_head_still_a", out_Data, 32'hA);
      cyc();
      chk("skid_stall_cnt", 32'(out_StallCount), 3);
      pushExp(32'hA, 11'h123);
      pushExp(32'hB, 11'h124);
      pushExp(32'hC, 11'h125);
      out_Ready = 1'b1;
      cyc();
      chk("skid_head_b", out_Data, 32'hB);
      chk("skid_ready_back", 32'(in_Ready), 1);
      cyc();
      in_Valid = 1'b0;
      chk("skid_head_c", out_Data, 32'hC);
      cyc();
      chk("skid_drained", 32'(out_Valid), 0);

      // Flush priority over accept and drain
      out_Ready = 1'b0;
      in_Valid  = 1'b1;
      in_Data   = 32'h11;
      in_Ctrl   = 11'h0F0;
      cyc();
      in_Data = 32'h22;
      in_Ctrl = 11'h0F1;
      cyc();
      chk("flush_pre_full", 32'(in_Ready), 0);
      chk("flush_pre_stall", 32'(out_StallCount), 4);
      in_Flush  = 1'b1;
      in_Data   = 32'hD;
      in_Ctrl   = 11'h7FF;
      out_Ready = 1'b1;
      pushExp(32'h11, 11'h0F0);
      cyc();
      in_Flush = 1'b0;
      in_Valid = 1'b0;
      chk("flush_out_valid", 32'(out_Valid), 0);
      chk("flush_out_ctrl", 32'(out_Ctrl), 0);
      chk("flush_in_ready", 32'(in_Ready), 1);
      chk("flush_data_kept", out_Data, 32'h11);
      chk("flush_stall_kept", 32'(out_StallCount), 4);
      for (int i = 0; i < 3; i++) cyc();
      chk("flush_no_ghost", 32'(out_Valid), 0);

      // Bubble gating of a stale control value
      in_Valid = 1'b1;
      in_Data  = 32'h33;
      in_Ctrl  = 11'h5A5;
      pushExp(32'h33, 11'h5A5);
      cyc();
      in_Valid = 1'b0;
      chk("bubble_live_ctrl", 32'(out_Ctrl), 32'h5A5);
      cyc();
      chk("bubble_valid", 32'(out_Valid), 0);
      chk("bubble_ctrl_gated", 32'(out_Ctrl), 0);

      // Stall counter saturation
      out_Ready = 1'b0;
      in_Valid  = 1'b1;
      in_Data   = 32'h44;
      in_Ctrl   = 11'h044;
      cyc();
      in_Valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (i == 5)  chk("sat_cnt_9", 32'(out_StallCount), 9);
         if (i == 11) chk("sat_cnt_15", 32'(out_StallCount), 15);
      end
      chk("sat_cnt_hold", 32'(out_StallCount), 15);
      in_Flush = 1'b1;
      cyc();
      in_Flush = 1'b0;
      chk("sat_after_flush", 32'(out_StallCount), 15);
      chk("sat_flushed", 32'(out_Valid), 0);

      // Asynchronous reset while FULL
      in_Valid = 1'b1;
      in_Data  = 32'h55;
      in_Ctrl  = 11'h155;
      cyc();
      in_Data = 32'h66;
      in_Ctrl = 11'h166;
      cyc();
      in_Valid = 1'b0;
      chk("rst2_pre_full", 32'(in_Ready), 0);
      #2;
      reset = 1'b0;
      #1;
      chk("rst2_out_valid", 32'(out_Valid), 0);
      chk("rst2_out_ctrl", 32'(out_Ctrl), 0);
      chk("rst2_out_data", out_Data, 0);
      chk("rst2_in_ready", 32'(in_Ready), 1);
      chk("rst2_stall", 32'(out_StallCount), 0);
      cyc();
      reset     = 1'b1;
      out_Ready = 1'b1;
      in_Valid  = 1'b1;
      in_Data   = 32'h77;
      in_Ctrl   = 11'h177;
      pushExp(32'h77, 11'h177);
      cyc();
      in_Valid = 1'b0;
      chk("post_rst_accept", out_Data, 32'h77);
      chk("post_rst_valid", 32'(out_Valid), 1);
      cyc();
      cyc();
      chk("queue_drained", 32'(expQ.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
